// File: rtl/sudoku_pkg.sv
// Shared state codes, difficulty codes and width/tap helpers for the Sudoku game controller.
package sudoku_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_CLEAR    = 4'd1,
        S_SET_DIFF = 4'd2,
        S_FILL     = 4'd3,
        S_PLAY     = 4'd4,
        S_CHECK    = 4'd5,
        S_WRONG    = 4'd6,
        S_WON      = 4'd7,
        S_LOST     = 4'd8
    } state_t;

    localparam logic [1:0] DIFF_NONE = 2'b00;
    localparam logic [1:0] DIFF_EASY = 2'b01;
    localparam logic [1:0] DIFF_MED  = 2'b10;
    localparam logic [1:0] DIFF_HARD = 2'b11;

    localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of a counter that must hold 0..v, never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (clog2(v + 1) < 1) ? 1 : clog2(v + 1);
    endfunction

    // Galois (right-shift) feedback masks for maximal-length sequences.
    function automatic logic [31:0] lfsr_taps(input int w);
        case (w)
            8:       return 32'h0000_00B8;
            24:      return 32'h00E1_0000;
            32:      return 32'hA300_0000;
            default: return 32'h0000_B400;
        endcase
    endfunction

endpackage

// File: rtl/sudoku_lfsr.sv
// Galois LFSR with synchronous seed load and step enable; exposes the low OUT_W state bits.
// Latency: new value visible the cycle after load/step. Backpressure: none, step is a plain enable.
// Load wins over step when both are asserted.
module sudoku_lfsr
    import sudoku_pkg::*;
#(
    parameter int             W       = 16,
    parameter int             OUT_W   = W,
    parameter logic [W-1:0]   RST_VAL = W'(LFSR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     seed,
    input  logic             step,
    output logic [OUT_W-1:0] q
);

    localparam logic [W-1:0] TAPS = W'(lfsr_taps(W));

    logic [W-1:0] r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r <= RST_VAL;
        end else if (load) begin
            r <= seed;
        end else if (step) begin
            r <= (r >> 1) ^ (r[0] ? TAPS : '0);
        end
    end

    assign q = r[OUT_W-1:0];

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game controller: new game -> difficulty -> random hint fill -> play/check loop -> WON/LOST.
// Latency: one state step per cycle; FILL tries one LFSR candidate per cycle; all outputs registered.
// Backpressure: checker handshake is chk_req (held through CHECK) / chk_ack, bounded by a timeout.
module sudoku_game_ctrl
    import sudoku_pkg::*;
#(
    parameter int N            = 4,
    parameter int HINTS_EASY   = 8,
    parameter int HINTS_MED    = 6,
    parameter int HINTS_HARD   = 4,
    parameter int MAX_MISTAKES = 3,
    parameter int CHK_TIMEOUT  = 16,
    parameter int LFSR_W       = 16
) (
    input  logic                             clka,
    input  logic                             restart_n,
    input  logic                             new_game,
    input  logic                             enter,
    input  logic [1:0]                       difficulty,
    input  logic [LFSR_W-1:0]                seed,
    input  logic                             chk_ack,
    input  logic                             chk_solved,
    output logic [3:0]                       state,
    output logic [N*N-1:0]                   fill_flag,
    output logic                             fill_valid,
    output logic                             chk_req,
    output logic [cnt_w(MAX_MISTAKES)-1:0]   mistakes,
    output logic                             won,
    output logic                             lost
);

    localparam int CELLS = N * N;
    localparam int IDXW  = (clog2(CELLS) < 1) ? 1 : clog2(CELLS);
    localparam int CW    = IDXW + 1;
    localparam int MW    = cnt_w(MAX_MISTAKES);
    localparam int TW    = cnt_w(CHK_TIMEOUT);

    localparam logic [CW-1:0] CELLS_V  = CW'(CELLS);
    localparam logic [CW-1:0] T_EASY   = CW'((HINTS_EASY > CELLS) ? CELLS : HINTS_EASY);
    localparam logic [CW-1:0] T_MED    = CW'((HINTS_MED  > CELLS) ? CELLS : HINTS_MED);
    localparam logic [CW-1:0] T_HARD   = CW'((HINTS_HARD > CELLS) ? CELLS : HINTS_HARD);
    localparam logic [TW-1:0] TMO_LAST = TW'(CHK_TIMEOUT - 1);
    localparam logic [MW-1:0] MIS_MAX  = {MW{1'b1}};

    state_t              state_q, state_nxt;
    logic                enter_q, enter_rise;
    logic [IDXW-1:0]     cand;
    logic [CW-1:0]       hint_cnt, target, diff_target;
    logic [TW-1:0]       tmo;
    logic                fill_hit, miss;
    logic [LFSR_W-1:0]   lfsr_seed;

    assign enter_rise = enter & ~enter_q;
    assign lfsr_seed  = (seed == '0) ? LFSR_W'(LFSR_DEFAULT) : seed;
    assign state      = state_q;

    sudoku_lfsr #(.W(LFSR_W), .OUT_W(IDXW)) u_lfsr (
        .clk   (clka),
        .rst_n (restart_n),
        .load  (state_q == S_CLEAR),
        .seed  (lfsr_seed),
        .step  (state_q == S_FILL),
        .q     (cand)
    );

    always_comb begin
        case (difficulty)
            DIFF_EASY: diff_target = T_EASY;
            DIFF_MED:  diff_target = T_MED;
            DIFF_HARD: diff_target = T_HARD;
            default:   diff_target = '0;
        endcase
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) state_q <= S_IDLE;
        else            state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        fill_hit  = 1'b0;
        miss      = 1'b0;
        case (state_q)
            S_IDLE:     state_nxt = S_CLEAR;
            S_CLEAR:    state_nxt = S_SET_DIFF;
            S_SET_DIFF: if (difficulty != DIFF_NONE)
                            state_nxt = (diff_target == '0) ? S_PLAY : S_FILL;
            S_FILL: begin
                // Out-of-range or already-given candidates are simply skipped.
                if (({1'b0, cand} < CELLS_V) && !fill_flag[cand]) begin
                    fill_hit = 1'b1;
                    if (hint_cnt + 1'b1 == target) state_nxt = S_PLAY;
                end
            end
            S_PLAY:     if (enter_rise) state_nxt = S_CHECK;
            S_CHECK: begin
                if (chk_ack && chk_solved) begin
                    state_nxt = S_WON;
                end else if (chk_ack || (tmo == TMO_LAST)) begin
                    miss = 1'b1;
                    if ((MAX_MISTAKES != 0) && (int'(mistakes) + 1 == MAX_MISTAKES))
                        state_nxt = S_LOST;
                    else
                        state_nxt = S_WRONG;
                end
            end
            S_WRONG:    if (enter_rise) state_nxt = S_PLAY;
            S_WON:      state_nxt = S_WON;
            S_LOST:     state_nxt = S_LOST;
            default:    state_nxt = S_IDLE;
        endcase
        if (new_game) begin
            state_nxt = S_CLEAR;
            fill_hit  = 1'b0;
            miss      = 1'b0;
        end
    end

    always_ff @(posedge clka or negedge restart_n) begin
        if (!restart_n) begin
            enter_q    <= 1'b0;
            fill_flag  <= '0;
            mistakes   <= '0;
            hint_cnt   <= '0;
            target     <= '0;
            tmo        <= '0;
            fill_valid <= 1'b0;
            chk_req    <= 1'b0;
            won        <= 1'b0;
            lost       <= 1'b0;
        end else begin
            enter_q    <= enter;
            // Flags track the state being entered so they line up with state.
            fill_valid <= (state_nxt >= S_PLAY);
            chk_req    <= (state_nxt == S_CHECK);
            won        <= (state_nxt == S_WON);
            lost       <= (state_nxt == S_LOST);
            tmo        <= ((state_q == S_CHECK) && (state_nxt == S_CHECK)) ? tmo + 1'b1 : '0;
            if (state_q == S_CLEAR) begin
                fill_flag <= '0;
                mistakes  <= '0;
                hint_cnt  <= '0;
            end
            if (state_q == S_SET_DIFF) target <= diff_target;
            if (fill_hit) begin
                fill_flag[cand] <= 1'b1;
                hint_cnt        <= hint_cnt + 1'b1;
            end
            if (miss && (mistakes != MIS_MAX)) mistakes <= mistakes + 1'b1;
        end
    end

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Self-checking bench for sudoku_game_ctrl: a 4x4 instance drives most scenarios, a 9x9 instance checks scaling.
module tb_sudoku_game_ctrl;

    localparam logic [3:0] ST_IDLE = 4'd0, ST_CLEAR = 4'd1, ST_SET_DIFF = 4'd2, ST_FILL = 4'd3,
                           ST_PLAY = 4'd4, ST_CHECK = 4'd5, ST_WRONG = 4'd6, ST_WON = 4'd7,
                           ST_LOST = 4'd8;

    logic        clka = 1'b0;
    logic        restart_n, new_game, enter, chk_ack, chk_solved;
    logic [1:0]  difficulty;
    logic [15:0] seed;

    logic [3:0]  state4, state9;
    logic [15:0] fill4;
    logic [80:0] fill9;
    logic        fill_valid4, chk_req4, won4, lost4;
    logic        fill_valid9, chk_req9, won9, lost9;
    logic [1:0]  mistakes4, mistakes9;

    int checks = 0;
    int errors = 0;
    int last_seed;

    sudoku_game_ctrl #(.N(4)) dut4 (
        .clka(clka), .restart_n(restart_n), .new_game(new_game), .enter(enter),
        .difficulty(difficulty), .seed(seed), .chk_ack(chk_ack), .chk_solved(chk_solved),
        .state(state4), .fill_flag(fill4), .fill_valid(fill_valid4), .chk_req(chk_req4),
        .mistakes(mistakes4), .won(won4), .lost(lost4)
    );

    sudoku_game_ctrl #(.N(9)) dut9 (
        .clka(clka), .restart_n(restart_n), .new_game(new_game), .enter(enter),
        .difficulty(difficulty), .seed(seed), .chk_ack(chk_ack), .chk_solved(chk_solved),
        .state(state9), .fill_flag(fill9), .fill_valid(fill_valid9), .chk_req(chk_req9),
        .mistakes(mistakes9), .won(won9), .lost(lost9)
    );

    always #5 clka = ~clka;

    // Next value of the hint-position generator: polynomial x^16+x^14+x^13+x^11+1, shifted toward bit 0.
    function automatic int lfsr_next(input int v);
        return ((v % 2) == 1) ? ((v / 2) ^ 32'hB400) : (v / 2);
    endfunction

    // Expected hint set: walk candidates from the seed, keeping each new in-range cell until target is met.
    task automatic fill_model(input int sd, input int cells, input int idxw, input int tgt,
                              output logic [80:0] flags, output int iters);
        int v, cnt, c;
        v = (sd == 0) ? 32'hACE1 : sd;
        flags = '0;
        cnt = 0;
        iters = 0;
        while (cnt < tgt && iters < 10000) begin
            c = v % (1 << idxw);
            if (c < cells && !flags[c]) begin
                flags[c] = 1'b1;
                cnt++;
            end
            v = lfsr_next(v);
            iters++;
        end
    endtask

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic wait_state(input bit nine, input logic [3:0] want, input int max,
                              output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        while (!ok && n < max) begin
            tick();
            n++;
            if ((nine ? state9 : state4) == want) ok = 1'b1;
        end
    endtask

    task automatic run_to_play(input int sd, input logic [1:0] df, output bit ok);
        int n;
        seed = 16'(sd);
        difficulty = df;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        tick();
        wait_state(1'b0, ST_PLAY, 200, n, ok);
    endtask

    task automatic test_reset();
        restart_n = 1'b1; new_game = 1'b0; enter = 1'b0; chk_ack = 1'b0; chk_solved = 1'b0;
        difficulty = 2'b01; seed = 16'd1;
        #2 restart_n = 1'b0;
        #1;
        checks++; if (state4 !== ST_IDLE) begin errors++; $display("FAIL reset_state got %0d want %0d", state4, ST_IDLE); end
        checks++; if (fill4 !== 16'h0) begin errors++; $display("FAIL reset_fill got %h want 0", fill4); end
        checks++; if ({fill_valid4, chk_req4, won4, lost4} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b want 0000", {fill_valid4, chk_req4, won4, lost4}); end
        checks++; if (mistakes4 !== 2'd0) begin errors++; $display("FAIL reset_mistakes got %0d want 0", mistakes4); end
        tick();
        checks++; if (state4 !== ST_IDLE) begin errors++; $display("FAIL reset_hold got %0d want %0d", state4, ST_IDLE); end
        restart_n = 1'b1;
        tick();
        checks++; if (state4 !== ST_CLEAR) begin errors++; $display("FAIL idle_to_clear got %0d want %0d", state4, ST_CLEAR); end
        tick();
        checks++; if (state4 !== ST_SET_DIFF) begin errors++; $display("FAIL clear_to_setdiff got %0d want %0d", state4, ST_SET_DIFF); end
    endtask

    task automatic test_easy_fill();
        logic [80:0] exp;
        int it, n;
        bit ok;
        tick();
        checks++; if (state4 !== ST_FILL) begin errors++; $display("FAIL easy_enter_fill got %0d want %0d", state4, ST_FILL); end
        wait_state(1'b0, ST_PLAY, 64, n, ok);
        fill_model(1, 16, 4, 8, exp, it);
        checks++; if (!ok) begin errors++; $display("FAIL easy_play_timeout got state %0d want %0d", state4, ST_PLAY); end
        checks++; if (n !== it) begin errors++; $display("FAIL easy_fill_cycles got %0d want %0d", n, it); end
        checks++; if (fill4 !== exp[15:0]) begin errors++; $display("FAIL easy_fill_flag got %h want %h", fill4, exp[15:0]); end
        checks++; if ($countones(fill4) !== 8) begin errors++; $display("FAIL easy_popcount got %0d want 8", $countones(fill4)); end
        checks++; if (fill_valid4 !== 1'b1) begin errors++; $display("FAIL easy_fill_valid got %b want 1", fill_valid4); end
    endtask

    task automatic test_hard_hold();
        logic [80:0] exp;
        int it, n, bad;
        bit ok;
        last_seed = $urandom_range(1, 65535);
        seed = 16'(last_seed);
        difficulty = 2'b00;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        checks++; if (state4 !== ST_SET_DIFF) begin errors++; $display("FAIL hold_setdiff got %0d want %0d", state4, ST_SET_DIFF); end
        bad = 0;
        repeat (20) begin
            tick();
            if (state4 !== ST_SET_DIFF) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL hold_20_cycles left SET_DIFF in %0d cycles want 0", bad); end
        difficulty = 2'b11;
        tick();
        checks++; if (state4 !== ST_FILL) begin errors++; $display("FAIL hard_enter_fill got %0d want %0d", state4, ST_FILL); end
        difficulty = 2'b01;
        wait_state(1'b0, ST_PLAY, 64, n, ok);
        fill_model(last_seed, 16, 4, 4, exp, it);
        checks++; if (!ok) begin errors++; $display("FAIL hard_play_timeout got state %0d want %0d", state4, ST_PLAY); end
        checks++; if (fill4 !== exp[15:0]) begin errors++; $display("FAIL hard_fill_flag got %h want %h", fill4, exp[15:0]); end
        checks++; if ($countones(fill4) !== 4) begin errors++; $display("FAIL hard_popcount got %0d want 4", $countones(fill4)); end
    endtask

    task automatic test_n9();
        logic [80:0] exp;
        int it, n;
        bit ok;
        wait_state(1'b1, ST_PLAY, 400, n, ok);
        fill_model(last_seed, 81, 7, 4, exp, it);
        checks++; if (!ok) begin errors++; $display("FAIL n9_play_timeout got state %0d want %0d", state9, ST_PLAY); end
        checks++; if (fill9 !== exp) begin errors++; $display("FAIL n9_fill_flag got %h want %h", fill9, exp); end
        checks++; if ($countones(fill9) !== 4) begin errors++; $display("FAIL n9_popcount got %0d want 4", $countones(fill9)); end
        checks++; if (fill_valid9 !== 1'b1) begin errors++; $display("FAIL n9_fill_valid got %b want 1", fill_valid9); end
    endtask

    task automatic test_win();
        logic [3:0] prev;
        int entries;
        logic req0;
        entries = 0;
        prev = state4;
        req0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            enter = 1'b1;
            chk_ack = (i == 3);
            chk_solved = (i == 3);
            tick();
            if (state4 == ST_CHECK && prev != ST_CHECK) entries++;
            if (i == 0) req0 = chk_req4;
            prev = state4;
        end
        enter = 1'b0; chk_ack = 1'b0; chk_solved = 1'b0;
        checks++; if (entries !== 1) begin errors++; $display("FAIL win_check_entries got %0d want 1", entries); end
        checks++; if (req0 !== 1'b1) begin errors++; $display("FAIL win_chk_req_in_check got %b want 1", req0); end
        checks++; if (state4 !== ST_WON) begin errors++; $display("FAIL win_state got %0d want %0d", state4, ST_WON); end
        checks++; if ({won4, lost4, chk_req4} !== 3'b100) begin errors++; $display("FAIL win_flags won/lost/req got %b want 100", {won4, lost4, chk_req4}); end
        repeat (3) tick();
        checks++; if (state4 !== ST_WON) begin errors++; $display("FAIL win_terminal got %0d want %0d", state4, ST_WON); end
    endtask

    task automatic test_lose();
        int n;
        bit ok;
        seed = 16'($urandom_range(1, 65535));
        difficulty = 2'b01;
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        checks++; if (state4 !== ST_CLEAR) begin errors++; $display("FAIL won_newgame_clear got %0d want %0d", state4, ST_CLEAR); end
        tick();
        tick();
        wait_state(1'b0, ST_PLAY, 200, n, ok);
        checks++; if (!ok) begin errors++; $display("FAIL lose_play_timeout got state %0d want %0d", state4, ST_PLAY); end
        for (int k = 1; k <= 3; k++) begin
            enter = 1'b1;
            tick();
            checks++; if (state4 !== ST_CHECK) begin errors++; $display("FAIL lose_enter_check[%0d] got %0d want %0d", k, state4, ST_CHECK); end
            chk_ack = 1'b1; chk_solved = 1'b0;
            tick();
            chk_ack = 1'b0;
            if (k < 3) begin
                checks++; if (state4 !== ST_WRONG) begin errors++; $display("FAIL lose_wrong[%0d] got %0d want %0d", k, state4, ST_WRONG); end
                checks++; if (mistakes4 !== 2'(k)) begin errors++; $display("FAIL lose_mistakes[%0d] got %0d want %0d", k, mistakes4, k); end
                tick();
                tick();
                checks++; if (state4 !== ST_WRONG) begin errors++; $display("FAIL wrong_needs_edge[%0d] got %0d want %0d", k, state4, ST_WRONG); end
                enter = 1'b0;
                tick();
                enter = 1'b1;
                tick();
                checks++; if (state4 !== ST_PLAY) begin errors++; $display("FAIL wrong_to_play[%0d] got %0d want %0d", k, state4, ST_PLAY); end
                enter = 1'b0;
                tick();
            end else begin
                checks++; if (state4 !== ST_LOST) begin errors++; $display("FAIL lose_state got %0d want %0d", state4, ST_LOST); end
                checks++; if (mistakes4 !== 2'd3) begin errors++; $display("FAIL lose_mistakes_final got %0d want 3", mistakes4); end
                checks++; if ({lost4, won4, chk_req4} !== 3'b100) begin errors++; $display("FAIL lose_flags lost/won/req got %b want 100", {lost4, won4, chk_req4}); end
            end
        end
        enter = 1'b0;
        repeat (3) tick();
        checks++; if (state4 !== ST_LOST) begin errors++; $display("FAIL lose_terminal got %0d want %0d", state4, ST_LOST); end
    endtask

    task automatic test_timeout();
        logic [80:0] exp;
        int it, n;
        bit ok;
        logic req_in;
        run_to_play(0, 2'b01, ok);
        fill_model(0, 16, 4, 8, exp, it);
        checks++; if (!ok) begin errors++; $display("FAIL tmo_play_timeout got state %0d want %0d", state4, ST_PLAY); end
        checks++; if (fill4 !== exp[15:0]) begin errors++; $display("FAIL zero_seed_fill got %h want %h", fill4, exp[15:0]); end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        req_in = chk_req4;
        n = (state4 == ST_CHECK) ? 1 : 0;
        while (state4 == ST_CHECK && n < 40) begin
            tick();
            if (state4 == ST_CHECK) n++;
        end
        checks++; if (n !== 16) begin errors++; $display("FAIL tmo_cycles got %0d want 16", n); end
        checks++; if (req_in !== 1'b1) begin errors++; $display("FAIL tmo_chk_req got %b want 1", req_in); end
        checks++; if ({state4, chk_req4} !== {ST_WRONG, 1'b0}) begin errors++; $display("FAIL tmo_to_wrong state/req got %0d/%b want %0d/0", state4, chk_req4, ST_WRONG); end
        checks++; if (mistakes4 !== 2'd1) begin errors++; $display("FAIL tmo_mistakes got %0d want 1", mistakes4); end
        chk_ack = 1'b1; chk_solved = 1'b1;
        tick();
        chk_ack = 1'b0; chk_solved = 1'b0;
        tick();
        checks++; if ({state4, won4, mistakes4} !== {ST_WRONG, 1'b0, 2'd1}) begin errors++; $display("FAIL late_ack_ignored state/won/mistakes got %0d/%b/%0d want %0d/0/1", state4, won4, mistakes4, ST_WRONG); end
    endtask

    task automatic test_same_seed_async();
        logic [80:0] exp;
        logic [15:0] first;
        int it, n, sd;
        bit ok;
        sd = $urandom_range(1, 65535);
        run_to_play(sd, 2'b10, ok);
        first = fill4;
        fill_model(sd, 16, 4, 6, exp, it);
        checks++; if (!ok || first !== exp[15:0]) begin errors++; $display("FAIL med_fill got %h ok=%0b want %h", first, ok, exp[15:0]); end
        run_to_play(sd, 2'b10, ok);
        checks++; if (fill4 !== first) begin errors++; $display("FAIL same_seed_repeat got %h want %h", fill4, first); end
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        tick();
        tick();
        tick();
        tick();
        checks++; if (state4 !== ST_FILL) begin errors++; $display("FAIL mid_fill got %0d want %0d", state4, ST_FILL); end
        #2 restart_n = 1'b0;
        #1;
        checks++; if (state4 !== ST_IDLE) begin errors++; $display("FAIL async_reset_state got %0d want %0d", state4, ST_IDLE); end
        checks++; if ({fill4, fill_valid4, chk_req4, won4, lost4, mistakes4} !== 22'h0) begin errors++; $display("FAIL async_reset_outputs got fill=%h flags=%b want 0", fill4, {fill_valid4, chk_req4, won4, lost4}); end
        tick();
        restart_n = 1'b1;
        tick();
        tick();
        tick();
        wait_state(1'b0, ST_PLAY, 200, n, ok);
        checks++; if (!ok || fill4 !== first) begin errors++; $display("FAIL after_reset_fill got %h ok=%0b want %h", fill4, ok, first); end
    endtask

    initial begin
        test_reset();
        test_easy_fill();
        test_hard_hold();
        test_n9();
        test_win();
        test_lose();
        test_timeout();
        test_same_seed_async();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation time limit reached, got no completion want completion");
        $fatal(1);
    end

endmodule
